// File: rtl/operand_stack_if.sv
// Command/status bundle between the calculator control FSM and the operand stack.
// The control side takes the master modport, the stack takes the slave modport.
interface operand_stack_if #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic [BITS-1:0] d;
  logic            push;
  logic            pop;
  logic            swap;
  logic            dup;
  logic            clear;
  logic            err_clr;
  logic [BITS-1:0] top;
  logic [BITS-1:0] second;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            overflow;
  logic            underflow;

  modport master (
    output d, push, pop, swap, dup, clear, err_clr,
    input  top, second, count, empty, full, overflow, underflow
  );

  modport slave (
    input  d, push, pop, swap, dup, clear, err_clr,
    output top, second, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/operand_stack.sv
// DEPTH-entry LIFO operand store with push/pop/replace/swap/dup/clear and sticky
// error flags. Entry 0 is the top; the array shifts on push and pop.
module operand_stack #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            reset,
  operand_stack_if.slave stk
);
  logic [BITS-1:0] ent_q [DEPTH];
  logic [BITS-1:0] ent_d [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            ovf_q;
  logic            ovf_d;
  logic            udf_q;
  logic            udf_d;
  logic            ovf_set_s;
  logic            udf_set_s;
  logic            has1_s;
  logic            has2_s;
  logic            full_s;

  assign has1_s = (count_q != {CW{1'b0}});
  assign has2_s = (count_q > CW'(1));
  assign full_s = (count_q == CW'(DEPTH));

  // Command decode in priority order; error cases leave contents and count alone.
  always_comb begin
    ent_d     = ent_q;
    count_d   = count_q;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    if (stk.clear) begin
      count_d = {CW{1'b0}};
    end else if (stk.push && stk.pop) begin
      if (has1_s) begin
        ent_d[0] = stk.d;
      end else begin
        udf_set_s = 1'b1;
      end
    end else if (stk.push) begin
      if (!full_s) begin
        ent_d[0] = stk.d;
        for (int i = 1; i < DEPTH; i++) ent_d[i] = ent_q[i-1];
        count_d = count_q + CW'(1);
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (stk.pop) begin
      if (has1_s) begin
        for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
        ent_d[DEPTH-1] = {BITS{1'b0}};
        count_d = count_q - CW'(1);
      end else begin
        udf_set_s = 1'b1;
      end
    end else if (stk.swap) begin
      if (has2_s) begin
        ent_d[0] = ent_q[1];
        ent_d[1] = ent_q[0];
      end else begin
        udf_set_s = 1'b1;
      end
    end else if (stk.dup) begin
      if (!has1_s) begin
        udf_set_s = 1'b1;
      end else if (full_s) begin
        ovf_set_s = 1'b1;
      end else begin
        for (int i = 1; i < DEPTH; i++) ent_d[i] = ent_q[i-1];
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = count_q;
    end
    // A new error in the same cycle as err_clr still sets the flag.
    ovf_d = ovf_set_s | (ovf_q & ~stk.err_clr);
    udf_d = udf_set_s | (udf_q & ~stk.err_clr);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= {BITS{1'b0}};
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Entries beyond count may be stale after clear, so mask them.
  assign stk.top       = has1_s ? ent_q[0] : {BITS{1'b0}};
  assign stk.second    = has2_s ? ent_q[1] : {BITS{1'b0}};
  assign stk.count     = count_q;
  assign stk.empty     = ~has1_s;
  assign stk.full      = full_s;
  assign stk.overflow  = ovf_q;
  assign stk.underflow = udf_q;
endmodule
